// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: drives the fetch address into a code memory with
// a 1-cycle synchronous read, tracks the single in-flight read, and buffers the
// returned words in a 2-entry queue for decode. It also handles branch redirects
// and wrong-path flushes, halts at the end of memory, and faults on a misaligned
// branch target.
module fetch_sequencer #(
  parameter int unsigned MEM_BYTES = 68,
  parameter logic [31:0] RESET_PC  = 32'h0,
  parameter int unsigned DEPTH     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable_i,
  output logic [31:0] pc_o,
  input  logic [31:0] inst_i,
  input  logic        branch_i,
  input  logic [31:0] branch_target_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic        halted_o,
  output logic        fault_o
);

  localparam logic [31:0] LAST_PC = 32'(MEM_BYTES - 4);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT, S_FAULT} state_t;

  state_t           state_q;
  logic [31:0]      pc_q;
  logic             halted_q, fault_q;

  // in-flight read: one outstanding fetch at most, with the pc it was issued at
  logic             inflight_q;
  logic [31:0]      if_pc_q;

  // 2-entry ring buffer; 1-bit pointers since depth is fixed at 2
  logic [1:0][31:0] ent_inst_q;
  logic [1:0][31:0] ent_pc_q;
  logic             rd_ptr_q, wr_ptr_q;
  logic [1:0]       cnt_q;

  logic             pop, push, issue, flush, in_range, tgt_misal, redirect, fault_go;
  logic [2:0]       occ_sum;

  assign in_range  = (pc_q <= LAST_PC);
  assign tgt_misal = |branch_target_i[1:0];
  assign pop       = inst_valid_o & inst_ready_i;

  // A branch in RUN/HALT discards wrong-path words; a branch in IDLE only loads pc.
  assign redirect  = branch_i & ((state_q == S_RUN) | (state_q == S_HALT));
  assign fault_go  = branch_i & tgt_misal & (state_q != S_FAULT);
  assign flush     = redirect | fault_go;

  // Issue only if the word can land in the buffer, counting the head leaving now.
  // A pop implies cnt_q >= 1, so this sum never underflows.
  assign occ_sum   = 3'(cnt_q) + 3'(inflight_q) - 3'(pop);
  assign issue     = (state_q == S_RUN) & enable_i & ~branch_i &
                     (occ_sum < 3'(DEPTH)) & in_range;

  // a squashed in-flight word is simply dropped
  assign push      = inflight_q & ~flush;

  assign pc_o         = pc_q;
  assign inst_valid_o = (cnt_q != 2'd0);
  assign inst_o       = ent_inst_q[rd_ptr_q];
  assign inst_pc_o    = ent_pc_q[rd_ptr_q];
  assign halted_o     = halted_q;
  assign fault_o      = fault_q;

  // Control FSM: owns pc, state and the registered halted/fault flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (fault_go) begin
            state_q <= S_FAULT;
            fault_q <= 1'b1;
          end else begin
            if (branch_i) pc_q <= branch_target_i;
            if (enable_i) state_q <= S_RUN;
          end
        end
        S_RUN: begin
          if (branch_i) begin
            if (tgt_misal) begin
              state_q <= S_FAULT;
              fault_q <= 1'b1;
            end else begin
              // an out-of-range target is loaded here and halts on the next cycle
              pc_q <= branch_target_i;
            end
          end else if (!enable_i) begin
            state_q <= S_IDLE;
          end else if (!in_range) begin
            state_q  <= S_HALT;
            halted_q <= 1'b1;
          end else if (issue) begin
            pc_q <= pc_q + 32'd4;
          end
        end
        S_HALT: begin
          if (branch_i) begin
            halted_q <= 1'b0;
            if (tgt_misal) begin
              state_q <= S_FAULT;
              fault_q <= 1'b1;
            end else begin
              state_q <= S_RUN;
              pc_q    <= branch_target_i;
            end
          end
        end
        default: ; // FAULT is sticky until reset
      endcase
    end
  end

  // Track the outstanding read and the pc it was issued at.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q <= 1'b0;
      if_pc_q    <= 32'h0;
    end else begin
      inflight_q <= issue;
      if (issue) if_pc_q <= pc_q;
    end
  end

  // Instruction buffer: a flush wins over both push and pop in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_inst_q <= '0;
      ent_pc_q   <= '0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      cnt_q      <= 2'd0;
    end else if (flush) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      // on a full buffer with a pop, wr_ptr equals rd_ptr and the head is overwritten as it leaves
      if (push) begin
        ent_inst_q[wr_ptr_q] <= inst_i;
        ent_pc_q[wr_ptr_q]   <= if_pc_q;
        wr_ptr_q             <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_q + 2'(push) - 2'(pop);
    end
  end

  // the issue rule must guarantee that a returning word always has a slot
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && cnt_q == 2'd2));

endmodule

// File: tb/tb_fetch_sequencer.sv
// Testbench for fetch_sequencer. It runs directed scenarios followed by random
// traffic. A queue-based reference model predicts the outputs for every cycle.
module tb_fetch_sequencer;

  localparam int unsigned MEM_BYTES = 68;
  localparam logic [31:0] RESET_PC  = 32'h0;
  localparam logic [31:0] LAST      = 32'(MEM_BYTES - 4);

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        enable_i = 1'b0;
  logic [31:0] pc_o;
  logic [31:0] inst_i = 32'h0;
  logic        branch_i = 1'b0;
  logic [31:0] branch_target_i = 32'h0;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_valid_o;
  logic        inst_ready_i = 1'b0;
  logic        halted_o;
  logic        fault_o;

  int checks = 0;
  int errors = 0;

  fetch_sequencer #(.MEM_BYTES(MEM_BYTES), .RESET_PC(RESET_PC), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .enable_i(enable_i), .pc_o(pc_o), .inst_i(inst_i),
    .branch_i(branch_i), .branch_target_i(branch_target_i), .inst_o(inst_o),
    .inst_pc_o(inst_pc_o), .inst_valid_o(inst_valid_o), .inst_ready_i(inst_ready_i),
    .halted_o(halted_o), .fault_o(fault_o)
  );

  always #5 clk = ~clk;

  // code memory contents: distinct, address-derived words
  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h0100_0193) ^ 32'hDEAD_0000;
  endfunction

  // reference model: the buffer and the in-flight read are queues of pcs
  typedef enum {M_IDLE, M_RUN, M_HALT, M_FAULT} mst_t;
  mst_t        m_st;
  logic [31:0] m_pc;
  logic [31:0] m_buf[$];
  logic [31:0] m_infl[$];

  logic [31:0] last_pop_pc;
  logic [31:0] delivered[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st = M_IDLE;
    m_pc = RESET_PC;
    m_buf.delete();
    m_infl.delete();
  endtask

  // advance the model by one clock edge for the given inputs
  task automatic model_step(input bit en, input bit br, input logic [31:0] tgt, input bit rdy);
    int  occ, fl;
    bit  pop;
    occ = m_buf.size();
    fl  = m_infl.size();
    pop = (occ > 0) && rdy;
    if (m_st == M_FAULT) return;
    if (br && tgt[1:0] != 2'b00) begin
      m_buf.delete(); m_infl.delete(); m_st = M_FAULT;
      return;
    end
    if (br && m_st != M_IDLE) begin
      m_buf.delete(); m_infl.delete(); m_pc = tgt; m_st = M_RUN;
      return;
    end
    if (pop) void'(m_buf.pop_front());
    if (fl > 0) begin
      m_buf.push_back(m_infl[0]);
      m_infl.delete();
    end
    case (m_st)
      M_IDLE: begin
        if (br) m_pc = tgt;
        if (en) m_st = M_RUN;
      end
      M_RUN: begin
        if (!en) m_st = M_IDLE;
        else if (m_pc > LAST) m_st = M_HALT;
        else if (occ + fl - int'(pop) < 2) begin
          m_infl.push_back(m_pc);
          m_pc = m_pc + 32'd4;
        end
      end
      default: ;
    endcase
  endtask

  task automatic check_outputs();
    chk("pc_o", pc_o, m_pc);
    chk("inst_valid_o", 32'(inst_valid_o), 32'(m_buf.size() > 0));
    if (m_buf.size() > 0) begin
      chk("inst_pc_o", inst_pc_o, m_buf[0]);
      chk("inst_o", inst_o, memf(m_buf[0]));
    end
    chk("halted_o", 32'(halted_o), 32'(m_st == M_HALT));
    chk("fault_o", 32'(fault_o), 32'(m_st == M_FAULT));
  endtask

  // One clock cycle. It is entered and left at a falling edge: the task checks
  // the current outputs, drives the inputs, and then returns the memory word
  // for the address that was sampled at the rising edge.
  task automatic cyc(input bit en, input bit br, input logic [31:0] tgt, input bit rdy);
    logic [31:0] p;
    check_outputs();
    enable_i = en; branch_i = br; branch_target_i = tgt; inst_ready_i = rdy;
    if (inst_valid_o && rdy) begin
      last_pop_pc = inst_pc_o;
      delivered.push_back(inst_pc_o);
    end
    p = pc_o;
    model_step(en, br, tgt, rdy);
    @(posedge clk);
    #1;
    inst_i   = memf(p);
    branch_i = 1'b0;
    @(negedge clk);
  endtask

  // Assert reset away from any rising edge and check that the outputs clear at once.
  task automatic do_reset();
    rst_n = 1'b0;
    enable_i = 1'b0; branch_i = 1'b0; inst_ready_i = 1'b0; inst_i = 32'h0;
    #1;
    chk("rst pc_o", pc_o, RESET_PC);
    chk("rst inst_valid_o", 32'(inst_valid_o), 32'h0);
    chk("rst inst_o", inst_o, 32'h0);
    chk("rst inst_pc_o", inst_pc_o, 32'h0);
    chk("rst halted_o", 32'(halted_o), 32'h0);
    chk("rst fault_o", 32'(fault_o), 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int k;
    int r;
    bit en, rdy, br;
    logic [31:0] tgt;

    // Scenario 1: reset, then free-run to the end of memory.
    #2;
    do_reset();
    for (int i = 0; i < 24; i++) cyc(1, 0, 32'h0, 1);
    chk("end halted_o", 32'(halted_o), 32'h1);
    chk("end pc_o", pc_o, 32'h44);
    chk("end last pc", last_pop_pc, 32'h40);
    cyc(1, 1, 32'h0, 1);
    for (int i = 0; i < 6; i++) cyc(1, 0, 32'h0, 1);
    chk("resume halted_o", 32'(halted_o), 32'h0);

    // Scenario 2: decode stalled from the start, then released.
    do_reset();
    for (int i = 0; i < 8; i++) cyc(1, 0, 32'h0, 0);
    chk("stall pc_o", pc_o, 32'h8);
    delivered.delete();
    for (int i = 0; i < 5; i++) cyc(1, 0, 32'h0, 1);
    chk("order n", 32'(delivered.size() >= 3), 32'h1);
    if (delivered.size() >= 3) begin
      chk("order 0", delivered[0], 32'h0);
      chk("order 1", delivered[1], 32'h4);
      chk("order 2", delivered[2], 32'h8);
    end

    // Scenario 3: branch while the buffer is full; count cycles to the target word.
    do_reset();
    for (int i = 0; i < 6; i++) cyc(1, 0, 32'h0, 0);
    cyc(1, 1, 32'h10, 1);
    k = 1;
    while (!inst_valid_o && k < 10) begin
      cyc(1, 0, 32'h0, 0);
      k++;
    end
    chk("branch latency", 32'(k), 32'd3);
    chk("branch first pc", inst_pc_o, 32'h10);
    for (int i = 0; i < 6; i++) cyc(1, 0, 32'h0, 1);

    // Scenario 4: misaligned target faults; later branches are ignored.
    cyc(1, 1, 32'h22, 1);
    chk("fault_o", 32'(fault_o), 32'h1);
    chk("fault valid", 32'(inst_valid_o), 32'h0);
    cyc(1, 1, 32'h0, 1);
    for (int i = 0; i < 4; i++) cyc(1, 0, 32'h0, 1);
    do_reset();
    cyc(0, 0, 32'h0, 0);

    // Scenario 5: asynchronous reset mid-stream with a full buffer.
    for (int i = 0; i < 6; i++) cyc(1, 0, 32'h0, 0);
    chk("full before rst", 32'(inst_valid_o), 32'h1);
    do_reset();

    // Scenario 6: random traffic.
    for (int seg = 0; seg < 3; seg++) begin
      for (int i = 0; i < 400; i++) begin
        en  = ($urandom_range(0, 9) != 0);
        rdy = ($urandom_range(0, 3) != 0);
        br  = ($urandom_range(0, 19) == 0);
        r   = int'($urandom_range(0, 19));
        if (r < 14)      tgt = 32'($urandom_range(0, 16)) << 2;
        else if (r < 16) tgt = 32'h44;
        else if (r < 18) tgt = 32'hFFFF_FFFC;
        else if (r < 19) tgt = 32'h0000_0080;
        else             tgt = (32'($urandom_range(0, 16)) << 2) | 32'($urandom_range(1, 3));
        cyc(en, br, tgt, rdy);
        if ($urandom_range(0, 199) == 0) do_reset();
      end
      do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
